// File: rtl/tpu_job_seq_if.sv
// rtl/tpu_job_seq_if.sv - host stream and TPU bus signals seen by the job sequencer
`timescale 1ns/1ps
interface tpu_job_seq_if #(
  parameter int DATAW = 64,
  parameter int ADDRW = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [DATAW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DATAW-1:0] out_data;
  logic             tpu_r_w;
  logic [ADDRW-1:0] tpu_addr;
  logic [DATAW-1:0] tpu_dataIn;
  logic [DATAW-1:0] tpu_dataOut;

  modport master (
    input  in_valid, in_data, out_ready, tpu_dataOut,
    output in_ready, out_valid, out_data, tpu_r_w, tpu_addr, tpu_dataIn
  );

  modport slave (
    output in_valid, in_data, out_ready, tpu_dataOut,
    input  in_ready, out_valid, out_data, tpu_r_w, tpu_addr, tpu_dataIn
  );
endinterface

// File: rtl/tpu_job_seq.sv
// rtl/tpu_job_seq.sv - loads A/B into the TPU, starts the matmul, drains, streams C back out
`timescale 1ns/1ps
module tpu_job_seq #(
  parameter int DIM   = 8,
  parameter int DATAW = 64,
  parameter int ADDRW = 16,
  parameter int DRAIN = 3*DIM
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  tpu_job_seq_if.master bus,
  output logic          busy,
  output logic          job_done,
  output logic [15:0]   jobs_cnt
);

  localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int CW = $clog2(2*DIM);
  localparam int WW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  localparam logic [ADDRW-1:0] A_BASE     = ADDRW'(16'h0100);
  localparam logic [ADDRW-1:0] B_BASE     = ADDRW'(16'h0200);
  localparam logic [ADDRW-1:0] C_BASE     = ADDRW'(16'h0300);
  localparam logic [ADDRW-1:0] START_ADDR = ADDRW'(16'h0400);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_START,
    S_WAIT,
    S_READ_C
  } state_t;

  state_t        state, state_n;
  logic [RW-1:0] row_cnt;
  logic [CW-1:0] rd_cnt;
  logic [WW-1:0] wait_cnt;

  logic in_hs, out_hs;
  logic last_row, last_rd, drain_done;

  assign last_row   = (row_cnt == RW'(DIM-1));
  assign last_rd    = (rd_cnt == CW'(2*DIM-1));
  assign drain_done = (wait_cnt == WW'(DRAIN-1));

  // C is read straight off the TPU's combinational read port
  assign bus.out_data = bus.tpu_dataOut;
  assign busy         = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      row_cnt  <= '0;
      rd_cnt   <= '0;
      wait_cnt <= '0;
      jobs_cnt <= '0;
    end else begin
      state <= state_n;
      if (clr) begin
        row_cnt  <= '0;
        rd_cnt   <= '0;
        wait_cnt <= '0;
      end else begin
        if (in_hs)
          row_cnt <= last_row ? '0 : row_cnt + RW'(1);
        if (state == S_WAIT)
          wait_cnt <= drain_done ? '0 : wait_cnt + WW'(1);
        if (out_hs)
          rd_cnt <= last_rd ? '0 : rd_cnt + CW'(1);
        if (job_done)
          jobs_cnt <= jobs_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    state_n        = state;
    bus.in_ready   = 1'b0;
    bus.out_valid  = 1'b0;
    bus.tpu_r_w    = 1'b0;
    bus.tpu_addr   = '0;
    bus.tpu_dataIn = bus.in_data;
    job_done       = 1'b0;
    in_hs          = 1'b0;
    out_hs         = 1'b0;

    case (state)
      S_IDLE: state_n = S_LOAD_A;

      S_LOAD_A, S_LOAD_B: begin
        bus.in_ready = !clr;
        in_hs        = bus.in_valid && !clr;
        // The bus write rides on the handshake cycle itself; idle cycles park the address at 0
        if (in_hs) begin
          bus.tpu_r_w  = 1'b1;
          bus.tpu_addr = ((state == S_LOAD_A) ? A_BASE : B_BASE) + (ADDRW'(row_cnt) << 3);
          if (last_row)
            state_n = (state == S_LOAD_A) ? S_LOAD_B : S_START;
        end
      end

      S_START: begin
        bus.tpu_r_w    = !clr;
        bus.tpu_addr   = START_ADDR;
        bus.tpu_dataIn = '0;
        state_n        = S_WAIT;
      end

      S_WAIT: begin
        if (drain_done)
          state_n = S_READ_C;
      end

      S_READ_C: begin
        bus.out_valid = !clr;
        out_hs        = bus.out_ready && !clr;
        bus.tpu_addr  = C_BASE | (ADDRW'(rd_cnt >> 1) << 4) | (ADDRW'(rd_cnt[0]) << 3);
        if (out_hs && last_rd) begin
          job_done = 1'b1;
          state_n  = S_LOAD_A;
        end
      end

      default: state_n = S_IDLE;
    endcase

    if (clr)
      state_n = S_IDLE;
  end

endmodule

// File: tb/tb_tpu_job_seq.sv
// tb/tb_tpu_job_seq.sv - random-stimulus bench for tpu_job_seq with a job-slot reference model
`timescale 1ns/1ps
module tb_tpu_job_seq;

  localparam int DIM   = 8;
  localparam int DRAIN = 3*DIM;
  localparam int NL    = 2*DIM;
  localparam int S_ST  = NL + 1;
  localparam int W0    = NL + 2;
  localparam int R0    = W0 + DRAIN;
  localparam int RL    = R0 + NL - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        busy, job_done;
  logic [15:0] jobs_cnt;

  tpu_job_seq_if #(.DATAW(64), .ADDRW(16)) bus ();

  tpu_job_seq #(.DIM(DIM), .DATAW(64), .ADDRW(16), .DRAIN(DRAIN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .bus      (bus),
    .busy     (busy),
    .job_done (job_done),
    .jobs_cnt (jobs_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // C[i][c] = sum_k A[i][k]*B[k][c] over byte elements, 16-bit results, four per half-row word
  function automatic logic [63:0] cword(input logic [63:0] a [DIM], input logic [63:0] b [DIM],
                                        input int i, input int h);
    logic [63:0] w;
    logic [15:0] s;
    w = '0;
    for (int c = 0; c < 4; c++) begin
      s = '0;
      for (int k = 0; k < DIM; k++)
        s += 16'(a[i][8*k +: 8]) * 16'(b[k][8*(4*h+c) +: 8]);
      w[16*c +: 16] = s;
    end
    return w;
  endfunction

  // Stand-in TPU: stores written rows, computes C on the start write, reads are combinational
  logic [63:0] ta [DIM];
  logic [63:0] tb [DIM];
  logic [63:0] tc [NL];
  initial begin
    for (int i = 0; i < DIM; i++) begin ta[i] = '0; tb[i] = '0; end
    for (int i = 0; i < NL; i++) tc[i] = '0;
  end
  always @(posedge clk) begin
    if (rst_n && bus.tpu_r_w) begin
      if (bus.tpu_addr[15:8] == 8'h01) ta[bus.tpu_addr[5:3]] <= bus.tpu_dataIn;
      else if (bus.tpu_addr[15:8] == 8'h02) tb[bus.tpu_addr[5:3]] <= bus.tpu_dataIn;
      else if (bus.tpu_addr == 16'h0400)
        for (int i = 0; i < DIM; i++)
          for (int h = 0; h < 2; h++) tc[2*i+h] <= cword(ta, tb, i, h);
    end
  end
  always_comb
    bus.tpu_dataOut = (bus.tpu_addr[15:8] == 8'h03) ? tc[{bus.tpu_addr[6:4], bus.tpu_addr[3]}] : 64'h0;

  // Stimulus knobs (written by the main sequence only)
  int          p_valid = 100;
  int          p_ready = 100;
  int          data_mode = 0;
  bit          hold5 = 1'b0;
  bit          capture = 1'b1;
  bit          period_chk = 1'b0;
  logic [15:0] cnt_adj = '0;

  // Reference model state: position of the job in a flat slot sequence
  int          mstep = 0;
  int          mjobs = 0;
  logic [15:0] mcnt = '0;
  logic [63:0] mA [DIM];
  logic [63:0] mB [DIM];
  logic [63:0] mC [NL];
  logic [63:0] got_c [$];
  int          cyc = 0;
  int          last_done = -1;
  int          held = 0;

  always @(posedge clk) begin
    #1;
    bus.in_valid = ($urandom_range(99) < p_valid);
    if (data_mode == 0 && mstep >= 1 && mstep <= NL) begin
      if (mstep <= DIM) bus.in_data = 64'h0101010101010101 * 64'(mstep);
      else              bus.in_data = 64'h1 << (8*(mstep-1-DIM));
    end else begin
      bus.in_data = {$urandom, $urandom};
    end
    if (hold5 && mstep == R0 + 5 && held < 10) begin
      bus.out_ready = 1'b0;
      held++;
    end else begin
      bus.out_ready = ($urandom_range(99) < p_ready);
    end
  end

  always @(negedge clk) begin
    bit   ld, rd, hin, hout, e_ir, e_ov, e_rw, e_done;
    int   j, k;
    logic [15:0] e_addr;
    cyc++;
    if (!rst_n) begin
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_tpu_r_w", 64'(bus.tpu_r_w), 64'd0);
      chk("rst_tpu_addr", 64'(bus.tpu_addr), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_job_done", 64'(job_done), 64'd0);
      chk("rst_jobs_cnt", 64'(jobs_cnt), 64'd0);
      mstep = 0;
      mcnt  = '0;
    end else begin
      ld     = (mstep >= 1 && mstep <= NL);
      rd     = (mstep >= R0 && mstep <= RL);
      e_ir   = ld && !clr;
      hin    = e_ir && bus.in_valid;
      e_ov   = rd && !clr;
      hout   = e_ov && bus.out_ready;
      e_rw   = hin || (mstep == S_ST && !clr);
      j      = mstep - R0;
      k      = mstep - 1;
      e_done = hout && (j == NL-1);

      chk("in_ready", 64'(bus.in_ready), 64'(e_ir));
      chk("out_valid", 64'(bus.out_valid), 64'(e_ov));
      chk("tpu_r_w", 64'(bus.tpu_r_w), 64'(e_rw));
      chk("busy", 64'(busy), 64'(mstep != 0));
      chk("job_done", 64'(job_done), 64'(e_done));
      chk("jobs_cnt", 64'(jobs_cnt), 64'(16'(mcnt + cnt_adj)));
      if (!clr) begin
        if (ld)               e_addr = !hin ? 16'h0 : (k < DIM) ? 16'(16'h0100 + 8*k) : 16'(16'h0200 + 8*(k-DIM));
        else if (mstep == S_ST) e_addr = 16'h0400;
        else if (rd)          e_addr = 16'(16'h0300 | ((j >> 1) << 4) | ((j & 1) << 3));
        else                  e_addr = 16'h0;
        chk("tpu_addr", 64'(bus.tpu_addr), 64'(e_addr));
      end
      if (e_rw) chk("tpu_dataIn", bus.tpu_dataIn, hin ? bus.in_data : 64'h0);
      if (e_ov) chk("out_data", bus.out_data, mC[j]);
      if (hold5 && e_ov && j == 5 && !bus.out_ready)
        chk("stall_addr", 64'(bus.tpu_addr), 64'h0328);
      if (capture && hout) got_c.push_back(bus.out_data);
      if (period_chk) begin
        if (job_done) begin
          if (last_done >= 0) chk("job_period", 64'(cyc - last_done), 64'd57);
          last_done = cyc;
        end
      end else begin
        last_done = -1;
      end

      if (clr) mstep = 0;
      else if (mstep == 0) mstep = 1;
      else if (ld) begin
        if (hin) begin
          if (k < DIM) mA[k] = bus.in_data;
          else         mB[k-DIM] = bus.in_data;
          if (mstep == NL)
            for (int i = 0; i < DIM; i++)
              for (int h = 0; h < 2; h++) mC[2*i+h] = cword(mA, mB, i, h);
          mstep++;
        end
      end else if (mstep < R0) mstep++;
      else if (hout) begin
        if (e_done) begin
          mstep = 1;
          mcnt  = mcnt + 16'd1;
          mjobs++;
        end else begin
          mstep++;
        end
      end
    end
  end

  task automatic wait_jobs(input int n, input int budget);
    int target, c;
    target = mjobs + n;
    c = 0;
    while (mjobs < target && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    if (mjobs < target) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_jobs: completed %0d required %0d", mjobs, target);
    end
  endtask

  task automatic wait_step(input int s, input int budget);
    int c;
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (mstep != s && c < budget);
    if (mstep != s) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_step: at step %0d required %0d", mstep, s);
    end
  endtask

  initial begin
    int first;
    rst_n = 1'b0;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fixed pattern job: A rows of repeated bytes, B identity
    first = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.tpu_r_w) begin
        first = n;
        break;
      end
    end
    chk("first_write_cycle", 64'(first), 64'd1);
    chk("first_write_addr", 64'(bus.tpu_addr), 64'h0100);
    wait_jobs(1, 200);
    chk("jobs_cnt_after_first", 64'(jobs_cnt), 64'd1);
    capture = 1'b0;
    chk("c_word_count", 64'(got_c.size()), 64'd16);
    if (got_c.size() == 16) begin
      chk("c_word_0", got_c[0], 64'h0001000100010001);
      chk("c_word_5", got_c[5], 64'h0003000300030003);
      chk("c_word_15", got_c[15], 64'h0008000800080008);
    end

    // Random data with input gaps
    data_mode = 1;
    p_valid = 50;
    wait_jobs(2, 600);

    // Output back-pressure plus a long stall on word 5
    p_valid = 100;
    p_ready = 70;
    hold5 = 1'b1;
    wait_jobs(2, 600);
    hold5 = 1'b0;
    chk("hold_cycles", 64'(held), 64'd10);

    // Soft clear in the tenth drain cycle
    p_ready = 100;
    wait_step(W0 + 10, 400);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("clr_idle_busy", 64'(busy), 64'd0);
    chk("clr_jobs_cnt", 64'(jobs_cnt), 64'd5);
    wait_jobs(1, 300);
    chk("jobs_after_clr", 64'(jobs_cnt), 64'd6);

    // Asynchronous reset during B row 3
    p_valid = 50;
    wait_step(DIM + 4, 600);
    #2 rst_n = 1'b0;
    #1;
    chk("async_in_ready", 64'(bus.in_ready), 64'd0);
    chk("async_tpu_r_w", 64'(bus.tpu_r_w), 64'd0);
    chk("async_tpu_addr", 64'(bus.tpu_addr), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_jobs_cnt", 64'(jobs_cnt), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_jobs(1, 400);
    chk("jobs_after_reset", 64'(jobs_cnt), 64'd1);

    // Stall-free back-to-back jobs across the counter wrap
    p_valid = 100;
    period_chk = 1'b1;
    wait_step(W0, 200);
    force dut.jobs_cnt = 16'hFFFE;
    cnt_adj = 16'hFFFE - mcnt;
    @(posedge clk);
    #1 release dut.jobs_cnt;
    wait_jobs(1, 200);
    chk("jobs_cnt_ffff", 64'(jobs_cnt), 64'hFFFF);
    wait_jobs(1, 200);
    chk("jobs_cnt_wrap", 64'(jobs_cnt), 64'h0000);
    wait_jobs(2, 300);
    chk("jobs_cnt_after_wrap", 64'(jobs_cnt), 64'h0002);
    period_chk = 1'b0;

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
